l0_cache_maint_ctrl: RTL and testbench

//  Maintenance sequencer for the L0 data cache valid-bit RAMs. Owns full-cache invalidation
//  (post-reset sweep, FENCE/FENCE.I flush) and queued single-index invalidations snooped from

---
 rtl/l0_cache_maint_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_l0_cache_maint_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/l0_cache_maint_ctrl.sv
// -----------------------------------------------------------------------------
// l0_cache_maint_ctrl
//   Maintenance sequencer for the L0 data cache valid-bit RAMs. Performs a
//   full-cache invalidation sweep after every reset and on each flush request
//   (FENCE/FENCE.I), and drains a small queue of single-index invalidations
//   snooped from external writers (DMA/debug). The valid-RAM write port is
//   shared with the pipeline write path; the pipeline is stalled only during
//   sweeps or when a queued snoop has been starved too long.
//
// Ports
//   i_clk, i_rst        clock; synchronous active-high reset
//   i_flush_req         1-cycle pulse: invalidate whole cache
//   i_snoop_valid/addr  snoop byte address offered by an external master
//   o_snoop_ready       snoop accepted on i_snoop_valid & o_snoop_ready
//   i_pipe_write_en     pipeline wants the valid-RAM write port this cycle
//   o_inval_we          clear all valid bits at o_inval_index (combinational)
//   o_inval_index       index being invalidated, 0 when o_inval_we=0
//   o_busy              sweep in progress; cache hits must be suppressed
//   o_stall_req         pipeline must stall (sweep or starved snoop)
//   o_flush_done        1-cycle pulse, cycle after the last sweep index
//
// Handshake: a snoop transfers on any cycle where i_snoop_valid and
// o_snoop_ready are both high; o_snoop_ready depends only on registered state
// (never on i_snoop_valid), so the master may hold valid with a stable address
// until it sees ready.
// -----------------------------------------------------------------------------
module l0_cache_maint_ctrl #(
  parameter int          CACHE_DEPTH         = 128,
  parameter int          MEM_BYTE_ADDR_WIDTH = 16,
  parameter logic [31:0] MMIO_ADDR           = 32'h4000_0000,
  parameter int          SNOOP_FIFO_DEPTH    = 4,
  parameter int          STARVE_LIMIT        = 8,
  localparam int         IDXW                = $clog2(CACHE_DEPTH)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush_req,
  input  logic            i_snoop_valid,
  input  logic [31:0]     i_snoop_addr,
  output logic            o_snoop_ready,
  input  logic            i_pipe_write_en,
  output logic            o_inval_we,
  output logic [IDXW-1:0] o_inval_index,
  output logic            o_busy,
  output logic            o_stall_req,
  output logic            o_flush_done
);

  localparam int PW = $clog2(SNOOP_FIFO_DEPTH);
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [0:0] {
    ST_SWEEP = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [IDXW-1:0] sweep_idx_q, sweep_idx_d;
  logic            flush_pend_q, flush_pend_d;
  logic            flush_done_q, flush_done_d;
  logic [CW-1:0]   starve_cnt_q, starve_cnt_d;
  logic            starve_stall_q, starve_stall_d;

  logic [IDXW-1:0] fifo_mem_q [SNOOP_FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW:0]     count_q, count_d;

  logic            fifo_full;
  logic            fifo_empty;
  logic            snoop_fire;
  logic            cacheable;
  logic            push;
  logic            pop;
  logic [IDXW-1:0] push_idx;

  assign fifo_full  = (count_q == (PW+1)'(SNOOP_FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);

  // During a sweep every snoop is swallowed: the sweep clears everything and
  // the pipeline cannot refill meanwhile, so ready is forced high.
  assign o_snoop_ready = !fifo_full || (state_q == ST_SWEEP);
  assign snoop_fire    = i_snoop_valid && o_snoop_ready;
  assign cacheable     = (i_snoop_addr < MMIO_ADDR) &&
                         (i_snoop_addr[31:MEM_BYTE_ADDR_WIDTH] == '0);
  assign push_idx      = i_snoop_addr[2 +: IDXW];

  assign o_busy       = (state_q == ST_SWEEP);
  assign o_stall_req  = (state_q == ST_SWEEP) || starve_stall_q;
  assign o_flush_done = flush_done_q;

  always_comb begin
    state_d        = state_q;
    sweep_idx_d    = sweep_idx_q;
    flush_pend_d   = flush_pend_q;
    flush_done_d   = 1'b0;
    starve_cnt_d   = starve_cnt_q;
    starve_stall_d = starve_stall_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    push           = 1'b0;
    pop            = 1'b0;
    o_inval_we     = 1'b0;
    o_inval_index  = '0;

    case (state_q)
      ST_SWEEP: begin
        o_inval_we     = 1'b1;
        o_inval_index  = sweep_idx_q;
        sweep_idx_d    = sweep_idx_q + 1'b1;
        starve_cnt_d   = '0;
        starve_stall_d = 1'b0;
        if (i_flush_req) flush_pend_d = 1'b1;
        if (sweep_idx_q == IDXW'(CACHE_DEPTH - 1)) begin
          flush_done_d = 1'b1;
          sweep_idx_d  = '0;
          // A flush arriving in the final cycle still needs a fresh sweep.
          if (flush_pend_q || i_flush_req) begin
            state_d      = ST_SWEEP;
            flush_pend_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin // ST_IDLE
        if (!fifo_empty) begin
          // Pipeline store wins the port unless the snoop has been starved
          // long enough to force a stall.
          if (!i_pipe_write_en || starve_stall_q) begin
            pop            = 1'b1;
            o_inval_we     = 1'b1;
            o_inval_index  = fifo_mem_q[rd_ptr_q];
            starve_cnt_d   = '0;
            starve_stall_d = 1'b0;
          end else begin
            if (starve_cnt_q < CW'(STARVE_LIMIT)) starve_cnt_d = starve_cnt_q + 1'b1;
            starve_stall_d = starve_stall_q || (starve_cnt_d == CW'(STARVE_LIMIT));
          end
        end

        push = snoop_fire && cacheable && !i_flush_req;

        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        case ({push, pop})
          2'b10:   count_d = count_q + 1'b1;
          2'b01:   count_d = count_q - 1'b1;
          default: count_d = count_q;
        endcase

        // Flush discards the queue; any pop this cycle has already issued.
        if (i_flush_req) begin
          state_d        = ST_SWEEP;
          sweep_idx_d    = '0;
          wr_ptr_d       = '0;
          rd_ptr_d       = '0;
          count_d        = '0;
          starve_cnt_d   = '0;
          starve_stall_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q        <= ST_SWEEP;
      sweep_idx_q    <= '0;
      flush_pend_q   <= 1'b0;
      flush_done_q   <= 1'b0;
      starve_cnt_q   <= '0;
      starve_stall_q <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
    end else begin
      state_q        <= state_d;
      sweep_idx_q    <= sweep_idx_d;
      flush_pend_q   <= flush_pend_d;
      flush_done_q   <= flush_done_d;
      starve_cnt_q   <= starve_cnt_d;
      starve_stall_q <= starve_stall_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
    end
  end

  // Queue storage needs no reset; entries are only read when count is nonzero.
  always_ff @(posedge i_clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= push_idx;
  end

endmodule

// File: tb/tb_l0_cache_maint_ctrl.sv
// -----------------------------------------------------------------------------
// tb_l0_cache_maint_ctrl
//   Directed bench: the driver pushes expected invalidation indices and
//   expected flush-done pulses; a monitor pops and compares whenever the DUT
//   asserts o_inval_we or o_flush_done. Cycle-exact handshake/stall points are
//   checked inline by the driver.
// -----------------------------------------------------------------------------
module tb_l0_cache_maint_ctrl;

  localparam int IDXW = 7;

  logic            clk;
  logic            rst;
  logic            flush_req;
  logic            snoop_valid;
  logic [31:0]     snoop_addr;
  logic            snoop_ready;
  logic            pipe_we;
  logic            inval_we;
  logic [IDXW-1:0] inval_index;
  logic            busy;
  logic            stall_req;
  logic            flush_done;

  int checks   = 0;
  int failures = 0;

  logic [IDXW-1:0] exp_q[$];
  int              done_exp = 0;

  l0_cache_maint_ctrl dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_flush_req     (flush_req),
    .i_snoop_valid   (snoop_valid),
    .i_snoop_addr    (snoop_addr),
    .o_snoop_ready   (snoop_ready),
    .i_pipe_write_en (pipe_we),
    .o_inval_we      (inval_we),
    .o_inval_index   (inval_index),
    .o_busy          (busy),
    .o_stall_req     (stall_req),
    .o_flush_done    (flush_done)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_sweep();
    for (int i = 0; i < 128; i++) exp_q.push_back(IDXW'(i));
    done_exp++;
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (inval_we) begin
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL inval_unexpected: actual index=%0d required=no write", inval_index);
        end else begin
          logic [IDXW-1:0] e;
          e = exp_q.pop_front();
          if (inval_index !== e) begin
            failures++;
            $display("FAIL inval_index: actual=%0d required=%0d", inval_index, e);
          end
        end
      end else if (inval_index !== '0) begin
        failures++;
        $display("FAIL idle_index: actual=%0d required=0", inval_index);
      end
      if (flush_done) begin
        checks++;
        if (done_exp == 0) begin
          failures++;
          $display("FAIL done_unexpected: actual=1 required=0");
        end else begin
          done_exp--;
        end
      end
    end
  end

  // driver
  initial begin
    int bad;
    rst = 1'b1; flush_req = 1'b0; snoop_valid = 1'b0; snoop_addr = '0; pipe_we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_busy", busy, 1);
    chk("rst_stall", stall_req, 1);
    chk("rst_done", flush_done, 0);
    chk("rst_ready", snoop_ready, 1);
    @(posedge clk); #1;

    // post-reset sweep
    expect_sweep();
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 128; c++) begin
      @(negedge clk);
      if (!(busy && stall_req && inval_we && !flush_done)) bad++;
      tick();
    end
    chk("sweep_window", bad, 0);
    @(negedge clk);
    chk("sweep_done_pulse", flush_done, 1);
    chk("sweep_busy_low", busy, 0);
    chk("sweep_stall_low", stall_req, 0);
    tick();
    @(negedge clk);
    chk("done_one_cycle", flush_done, 0);
    tick();

    // single snoop, port free
    snoop_valid = 1'b1; snoop_addr = 32'h0000_0104;
    exp_q.push_back(7'h41);
    @(negedge clk);
    chk("snoop_ready", snoop_ready, 1);
    chk("snoop_no_bypass", inval_we, 0);
    tick();
    snoop_valid = 1'b0;
    @(negedge clk);
    chk("snoop_inval_next", inval_we, 1);
    tick();

    // uncacheable snoops: accepted and dropped
    for (int k = 0; k < 3; k++) begin
      snoop_valid = 1'b1;
      snoop_addr = (k == 0) ? 32'h4000_0010 : (k == 1) ? 32'h0001_0000 : 32'hFFFF_FFFC;
      @(negedge clk);
      chk("drop_ready", snoop_ready, 1);
      tick();
    end
    snoop_valid = 1'b0;
    repeat (3) tick();

    // top cacheable address
    snoop_valid = 1'b1; snoop_addr = 32'h0000_FFFC;
    exp_q.push_back(7'h7F);
    tick();
    snoop_valid = 1'b0;
    @(negedge clk);
    chk("top_addr_inval", inval_we, 1);
    tick();

    // starvation
    pipe_we = 1'b1;
    snoop_valid = 1'b1; snoop_addr = 32'h0000_0008;
    exp_q.push_back(7'd2);
    tick();
    snoop_valid = 1'b0;
    bad = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (stall_req || inval_we) bad++;
      tick();
    end
    chk("starve_blocked", bad, 0);
    @(negedge clk);
    chk("starve_stall", stall_req, 1);
    chk("starve_pop", inval_we, 1);
    tick();
    @(negedge clk);
    chk("starve_stall_drop", stall_req, 0);
    tick();

    // fill queue, then flush with a pop in the same cycle
    for (int i = 0; i < 4; i++) begin
      snoop_valid = 1'b1; snoop_addr = 32'h10 + 32'(4 * i);
      @(negedge clk);
      chk("fill_ready", snoop_ready, 1);
      tick();
    end
    snoop_valid = 1'b1; snoop_addr = 32'h20;
    @(negedge clk);
    chk("full_ready_low", snoop_ready, 0);
    tick();
    snoop_valid = 1'b0;
    pipe_we = 1'b0;
    flush_req = 1'b1;
    exp_q.push_back(7'd4);
    expect_sweep();
    @(negedge clk);
    chk("flush_pop_same_cycle", inval_we, 1);
    tick();
    flush_req = 1'b0;
    @(negedge clk);
    chk("flush_busy", busy, 1);
    repeat (128) tick();
    @(negedge clk);
    chk("flush_done", flush_done, 1);
    chk("flush_busy_low", busy, 0);
    tick();
    @(negedge clk);
    chk("flush_ready_after", snoop_ready, 1);
    repeat (4) tick();

    // flush during sweep at index 50
    flush_req = 1'b1;
    expect_sweep();
    expect_sweep();
    tick();
    flush_req = 1'b0;
    repeat (50) tick();
    flush_req = 1'b1;
    @(negedge clk);
    chk("mid_sweep_index", inval_index, 50);
    tick();
    flush_req = 1'b0;
    repeat (77) tick();
    @(negedge clk);
    chk("pend_done1", flush_done, 1);
    chk("pend_busy", busy, 1);
    repeat (128) tick();
    @(negedge clk);
    chk("pend_done2", flush_done, 1);
    chk("pend_busy_low", busy, 0);
    repeat (4) tick();

    chk("exp_q_empty", exp_q.size(), 0);
    chk("done_all_seen", done_exp, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
